// File: rtl/pipe_stage_chain.sv
// Generic stall/flush-capable pipeline register chain with valid/ready handshake,
// bubble collapse, partial flush and debug counters. Stage 0 is youngest.

module pipe_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              drain,
  input  logic              kill,
  input  logic [DATA_W-1:0] src,
  output logic              vld,
  output logic [DATA_W-1:0] data
);
  // Kill beats load: a flushed stage never captures the predecessor's payload.
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      data <= '0;
    end else if (kill) begin
      vld <= 1'b0;
    end else if (load) begin
      vld  <= 1'b1;
      data <= src;
    end else if (drain) begin
      vld <= 1'b0;
    end
  end
endmodule

module pipe_stage_chain #(
  parameter int DATA_W = 32,
  parameter int STAGES = 4,
  parameter int IDX_W  = 4,
  parameter int CNT_W  = 16,
  localparam int OCC_W = $clog2(STAGES + 1)
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              flush_req,
  input  logic [IDX_W-1:0]  flush_stage,
  output logic [OCC_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  logic [STAGES-1:0]             v, move, kill, load;
  logic [STAGES-1:0][DATA_W-1:0] d, src;
  logic                          acc0;
  logic [OCC_W-1:0]              flushed;
  logic [CNT_W:0]                flush_sum;

  // Accept chain runs oldest to youngest: a stage empties if it is empty or its
  // successor empties, which lets bubbles collapse behind a stalled head.
  always_comb begin
    logic a;
    move = '0;
    a    = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      move[i] = v[i] & a;
      a       = ~v[i] | move[i];
    end
    acc0 = a;
  end

  assign in_ready = acc0 & ~flush_req;

  always_comb begin
    int kk;
    kk = int'(flush_stage);
    if (kk > STAGES - 1) kk = STAGES - 1;
    kill = '0;
    for (int i = 0; i < STAGES; i++) kill[i] = flush_req && (i <= kk);
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign load[g] = in_valid & in_ready;
      assign src[g]  = in_data;
    end else begin : g_body
      assign load[g] = move[g-1] & ~kill[g-1];
      assign src[g]  = d[g-1];
    end
    pipe_stage #(.DATA_W(DATA_W)) u_stage (
      .clk   (SYS_clk),
      .rst_n (SYS_reset_n),
      .load  (load[g]),
      .drain (move[g]),
      .kill  (kill[g]),
      .src   (src[g]),
      .vld   (v[g]),
      .data  (d[g])
    );
  end

  assign out_valid = v[STAGES-1];
  assign out_data  = d[STAGES-1];

  always_comb begin
    occupancy = '0;
    flushed   = '0;
    for (int i = 0; i < STAGES; i++) begin
      occupancy = occupancy + OCC_W'(v[i]);
      flushed   = flushed + OCC_W'(v[i] & kill[i]);
    end
  end

  assign flush_sum = {1'b0, flush_cnt} + (CNT_W+1)'(flushed);

  always_ff @(negedge SYS_clk) begin
    if (!SYS_reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (in_valid && !in_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      flush_cnt <= flush_sum[CNT_W] ? '1 : flush_sum[CNT_W-1:0];
    end
  end
endmodule

// File: tb/tb_pipe_stage_chain.sv
// Randomized and directed bench for pipe_stage_chain against a slot-list reference model.

module tb_pipe_stage_chain;
  localparam int S = 4;
  localparam int DW = 8;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic          flush_req = 1'b0;
  logic [3:0]    flush_stage = '0;
  logic [2:0]    occupancy;
  logic [3:0]    stall_cnt;
  logic [3:0]    flush_cnt;

  pipe_stage_chain #(.DATA_W(DW), .STAGES(S), .IDX_W(4), .CNT_W(4)) dut (
    .SYS_clk(clk), .SYS_reset_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .flush_req(flush_req), .flush_stage(flush_stage), .occupancy(occupancy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: slot list indexed by position, oldest at S-1.
  bit            mv[S];
  logic [DW-1:0] md[S];
  int            m_stall, m_flush;

  logic          obs_ir, obs_ov, exp_ir, exp_ov, fire_in;
  logic [DW-1:0] obs_od, exp_od;
  int            obs_occ, obs_stall, obs_flush, exp_occ, exp_stall, exp_flush;
  logic [DW-1:0] got[$];

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < S; i++) c += int'(mv[i]);
    return c;
  endfunction

  task automatic model_step();
    bit rdy;
    int k, fl;
    if (!rst_n) begin
      for (int i = 0; i < S; i++) begin mv[i] = 0; md[i] = '0; end
      m_stall = 0; m_flush = 0;
      return;
    end
    // Head can accept when any slot is free (the gap pulls everything up) or the output drains.
    rdy = !flush_req && (m_count() < S || out_ready);
    if (in_valid && !rdy && m_stall < CMAX) m_stall++;
    if (flush_req) begin
      k = (int'(flush_stage) > S - 1) ? S - 1 : int'(flush_stage);
      fl = 0;
      for (int i = 0; i <= k; i++) if (mv[i]) begin fl++; mv[i] = 0; end
      m_flush = (m_flush + fl > CMAX) ? CMAX : m_flush + fl;
    end
    if (mv[S-1] && out_ready) mv[S-1] = 0;
    for (int i = S - 2; i >= 0; i--)
      if (mv[i] && !mv[i+1]) begin mv[i+1] = 1; md[i+1] = md[i]; mv[i] = 0; end
    if (in_valid && rdy) begin mv[0] = 1; md[0] = in_data; end
  endtask

  // One clock: observe DUT and model just after the rising edge, update at the falling edge.
  task automatic cycle();
    #1;
    obs_ir = in_ready; obs_ov = out_valid; obs_od = out_data;
    obs_occ = int'(occupancy); obs_stall = int'(stall_cnt); obs_flush = int'(flush_cnt);
    exp_occ = m_count();
    exp_ir = !flush_req && (exp_occ < S || out_ready);
    exp_ov = mv[S-1]; exp_od = md[S-1];
    exp_stall = m_stall; exp_flush = m_flush;
    fire_in = in_valid && in_ready;
    if (out_valid && out_ready) got.push_back(out_data);
    @(negedge clk);
    model_step();
    @(posedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush_req = 1'b0; out_ready = 1'b0;
    cycle();
    rst_n = 1'b1;
    got.delete();
  endtask

  task automatic test_reset();
    do_reset();
    cycle();
    checks++; if (obs_occ !== 0) begin errors++; $display("FAIL reset_occ got=%0d want=0", obs_occ); end
    checks++; if (obs_ov !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", obs_ov); end
    checks++; if (obs_stall !== 0 || obs_flush !== 0) begin
      errors++; $display("FAIL reset_counters got=%0d/%0d want=0/0", obs_stall, obs_flush); end
    checks++; if (obs_ir !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", obs_ir); end
  endtask

  task automatic test_fill_stall();
    logic [DW-1:0] a_list[6];
    int idx = 0;
    a_list = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
    do_reset();
    repeat (8) begin
      in_valid = idx < 6; in_data = (idx < 6) ? a_list[idx] : '0;
      cycle();
      if (fire_in) idx++;
    end
    in_valid = 1'b1; in_data = a_list[idx < 6 ? idx : 5];
    cycle();
    if (fire_in) idx++;
    checks++; if (idx !== 4) begin errors++; $display("FAIL fill_accepted got=%0d want=4", idx); end
    checks++; if (obs_occ !== 4) begin errors++; $display("FAIL fill_occ got=%0d want=4", obs_occ); end
    checks++; if (obs_ir !== 1'b0) begin errors++; $display("FAIL fill_in_ready got=%b want=0", obs_ir); end
    checks++; if (obs_stall !== 4) begin errors++; $display("FAIL fill_stall_cnt got=%0d want=4", obs_stall); end
    out_ready = 1'b1;
    repeat (16) begin
      in_valid = idx < 6; in_data = (idx < 6) ? a_list[idx] : '0;
      cycle();
      if (fire_in) idx++;
    end
    in_valid = 1'b0;
    checks++; if (got.size() !== 6) begin errors++; $display("FAIL fill_out_count got=%0d want=6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== a_list[i]) begin errors++; $display("FAIL fill_order[%0d] got=%h want=%h", i, got[i], a_list[i]); end
    end
  endtask

  task automatic test_latency_stream();
    int lat = -1, first = -1, last = -1, n = 0;
    logic [DW-1:0] lat_data = '0;
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h10;
    cycle();
    in_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      cycle();
      if (obs_ov && lat < 0) begin lat = c; lat_data = obs_od; end
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL latency got=%0d want=4", lat); end
    checks++; if (lat_data !== 8'h10) begin errors++; $display("FAIL latency_data got=%h want=10", lat_data); end
    got.delete();
    for (int j = 0; j < 20; j++) begin
      in_valid = j < 8; in_data = DW'(8'h20 + j);
      cycle();
      if (obs_ov) begin if (first < 0) first = j; last = j; n++; end
    end
    in_valid = 1'b0;
    checks++; if (n !== 8 || last - first !== 7) begin
      errors++; $display("FAIL stream_gaps got=%0d outputs over %0d cycles want=8 over 8", n, last - first + 1); end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== DW'(8'h20 + i)) begin errors++; $display("FAIL stream_data[%0d] got=%h want=%h", i, got[i], 8'h20 + i); end
    end
  endtask

  task automatic test_partial_flush();
    do_reset();
    for (int i = 0; i < 4; i++) begin in_valid = 1'b1; in_data = DW'(8'hA1 + i); cycle(); end
    in_valid = 1'b0; flush_req = 1'b1; flush_stage = 4'd1;
    cycle();
    flush_req = 1'b0;
    cycle();
    checks++; if (obs_occ !== 2) begin errors++; $display("FAIL pflush_occ got=%0d want=2", obs_occ); end
    checks++; if (obs_flush !== 2) begin errors++; $display("FAIL pflush_cnt got=%0d want=2", obs_flush); end
    checks++; if (obs_ov !== 1'b1 || obs_od !== 8'hA1) begin
      errors++; $display("FAIL pflush_head got=%b/%h want=1/a1", obs_ov, obs_od); end
    out_ready = 1'b1; got.delete();
    repeat (6) cycle();
    checks++; if (got.size() !== 2) begin errors++; $display("FAIL pflush_out_count got=%0d want=2", got.size()); end
    if (got.size() == 2) begin
      checks++; if (got[0] !== 8'hA1 || got[1] !== 8'hA2) begin
        errors++; $display("FAIL pflush_out got=%h,%h want=a1,a2", got[0], got[1]); end
    end
  endtask

  task automatic test_bubble_full_flush();
    logic [DW-1:0] seq[10];
    seq = '{8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hB0, 8'h00, 8'hB1, 8'h00, 8'h00};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      in_valid = seq[i] != 8'h00; in_data = seq[i];
      cycle();
      if (i == 4) begin
        checks++; if (obs_ov !== 1'b1 || obs_od !== 8'hC0 || obs_occ !== 1) begin
          errors++; $display("FAIL collapse_head got=%b/%h/%0d want=1/c0/1", obs_ov, obs_od, obs_occ); end
      end
    end
    checks++; if (obs_occ !== 3) begin errors++; $display("FAIL collapse_occ got=%0d want=3", obs_occ); end
    in_valid = 1'b1; in_data = 8'hD0;
    cycle();
    flush_req = 1'b1; flush_stage = 4'd7;
    cycle();
    checks++; if (obs_ir !== 1'b0) begin errors++; $display("FAIL flushall_in_ready got=%b want=0", obs_ir); end
    flush_req = 1'b0; in_valid = 1'b0;
    cycle();
    checks++; if (obs_occ !== 0 || obs_ov !== 1'b0) begin
      errors++; $display("FAIL flushall_occ got=%0d/%b want=0/0", obs_occ, obs_ov); end
    checks++; if (obs_flush !== 4) begin errors++; $display("FAIL flushall_cnt got=%0d want=4", obs_flush); end
    checks++; if (obs_stall !== 1) begin errors++; $display("FAIL flushall_stall got=%0d want=1", obs_stall); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 3; i++) begin in_valid = 1'b1; in_data = DW'(8'h50 + i); cycle(); end
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hEE;
    cycle();
    rst_n = 1'b1; in_valid = 1'b0;
    cycle();
    checks++; if (obs_occ !== 0 || obs_ov !== 1'b0) begin
      errors++; $display("FAIL midreset_state got=%0d/%b want=0/0", obs_occ, obs_ov); end
    checks++; if (obs_stall !== 0 || obs_flush !== 0) begin
      errors++; $display("FAIL midreset_cnt got=%0d/%0d want=0/0", obs_stall, obs_flush); end
    repeat (5) cycle();
    checks++; if (obs_occ !== 0) begin errors++; $display("FAIL midreset_capture got=%0d want=0", obs_occ); end
  endtask

  task automatic test_saturation();
    do_reset();
    in_valid = 1'b1; in_data = 8'h77;
    repeat (24) cycle();
    in_valid = 1'b0;
    cycle();
    checks++; if (obs_stall !== 15) begin errors++; $display("FAIL stall_sat got=%0d want=15", obs_stall); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst_n       = ($urandom_range(0, 99) >= 2);
      in_valid    = ($urandom_range(0, 99) < 70);
      in_data     = DW'($urandom);
      out_ready   = ($urandom_range(0, 99) < 60);
      flush_req   = ($urandom_range(0, 99) < 8);
      flush_stage = 4'($urandom_range(0, 15));
      cycle();
      checks++; if (obs_ir !== exp_ir) begin errors++; $display("FAIL rnd_in_ready c=%0d got=%b want=%b", c, obs_ir, exp_ir); end
      checks++; if (obs_ov !== exp_ov) begin errors++; $display("FAIL rnd_out_valid c=%0d got=%b want=%b", c, obs_ov, exp_ov); end
      if (exp_ov) begin
        checks++; if (obs_od !== exp_od) begin errors++; $display("FAIL rnd_out_data c=%0d got=%h want=%h", c, obs_od, exp_od); end
      end
      checks++; if (obs_occ !== exp_occ) begin errors++; $display("FAIL rnd_occ c=%0d got=%0d want=%0d", c, obs_occ, exp_occ); end
      checks++; if (obs_stall !== exp_stall) begin errors++; $display("FAIL rnd_stall c=%0d got=%0d want=%0d", c, obs_stall, exp_stall); end
      checks++; if (obs_flush !== exp_flush) begin errors++; $display("FAIL rnd_flush c=%0d got=%0d want=%0d", c, obs_flush, exp_flush); end
    end
    rst_n = 1'b1; flush_req = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < S; i++) begin mv[i] = 0; md[i] = '0; end
    m_stall = 0; m_flush = 0;
    @(posedge clk);
    test_reset();
    test_fill_stall();
    test_latency_stream();
    test_partial_flush();
    test_bubble_full_flush();
    test_reset_midstream();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
